// File: rtl/array_urate_os.sv
// Output-stationary rate-coded (unary) GEMM array with built-in step sequencer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   rank-1 step handshake (ifm column, wght row, acc_clr, last)
//   acc_clr, last       per-step: zero accumulators first / drain after this step
//   ifm                 HEIGHT sign-magnitude operands, row h at [h*IWIDTH +: IWIDTH]
//   wght                WIDTH sign-magnitude operands, column w at [w*IWIDTH +: IWIDTH]
//   busy                sequencer not idle
//   ofm_valid/ofm_ready row drain handshake
//   ofm_row, ofm        row index and its WIDTH accumulators, column w at [w*OWIDTH +: OWIDTH]
module array_urate_os #(
  parameter int unsigned HEIGHT = 12,
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned OWIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  acc_clr,
  input  logic                                  last,
  input  logic [HEIGHT*IWIDTH-1:0]              ifm,
  input  logic [WIDTH*IWIDTH-1:0]               wght,
  output logic                                  busy,
  output logic                                  ofm_valid,
  input  logic                                  ofm_ready,
  output logic [(HEIGHT>1?$clog2(HEIGHT):1)-1:0] ofm_row,
  output logic [WIDTH*OWIDTH-1:0]               ofm
);
  localparam int unsigned M  = IWIDTH - 1;
  localparam int unsigned L  = 1 << M;
  localparam int unsigned CW = $clog2(L + WIDTH);
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [OWIDTH-1:0] ACC_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] ACC_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMP, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cyc, cyc_nxt;
  logic [CW:0]       cyc_p1;
  logic [RW-1:0]     row, row_nxt;
  logic              accept;
  logic              last_q;
  logic [M-1:0]      imag_q [HEIGHT];
  logic [M-1:0]      wmag_q [WIDTH];
  logic              wsgn_q [WIDTH];
  logic              bit_q  [HEIGHT][WIDTH];
  logic              sgn_q  [HEIGHT][WIDTH];
  logic              col0_bit [HEIGHT];
  logic [M-1:0]      cnt     [HEIGHT][WIDTH];
  logic [M-1:0]      cnt_nxt [HEIGHT][WIDTH];
  logic [OWIDTH-1:0] acc     [HEIGHT][WIDTH];
  logic [OWIDTH-1:0] acc_nxt [HEIGHT][WIDTH];
  logic [WIDTH*OWIDTH-1:0] ofm_nxt;

  function automatic logic [M-1:0] bitrev(input logic [M-1:0] x);
    logic [M-1:0] r;
    for (int i = 0; i < M; i++) r[i] = x[M-1-i];
    return r;
  endfunction

  // Sequencer: accept step, run L+WIDTH-1 compute cycles, optionally drain rows
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    row_nxt   = row;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = COMP;
          cyc_nxt   = '0;
        end
      end
      COMP: begin
        cyc_nxt = cyc + CW'(1);
        if (cyc == CW'(L + WIDTH - 2)) begin
          cyc_nxt   = '0;
          state_nxt = last_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (ofm_ready) begin
          if (row == RW'(HEIGHT - 1)) begin
            row_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            row_nxt = row + RW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PE array: unary multiply via bit-reversed counter, saturating accumulate
  always_comb begin
    cyc_p1 = (CW+1)'(cyc) + (CW+1)'(1);
    for (int h = 0; h < HEIGHT; h++) begin
      // Column 0 is preloaded with t=0 on accept, so during COMP it takes t=cyc+1
      col0_bit[h] = (cyc_p1 < (CW+1)'(L)) && (cyc_p1 < (CW+1)'(imag_q[h]));
      for (int w = 0; w < WIDTH; w++) begin
        acc_nxt[h][w] = acc[h][w];
        cnt_nxt[h][w] = cnt[h][w];
        if (accept) begin
          cnt_nxt[h][w] = '0;
          if (acc_clr) acc_nxt[h][w] = '0;
        end else if (state == COMP && bit_q[h][w]) begin
          cnt_nxt[h][w] = cnt[h][w] + M'(1);
          if (bitrev(cnt[h][w]) < wmag_q[w]) begin
            if (sgn_q[h][w] ^ wsgn_q[w]) begin
              if (acc[h][w] != ACC_MIN) acc_nxt[h][w] = acc[h][w] - OWIDTH'(1);
            end else begin
              if (acc[h][w] != ACC_MAX) acc_nxt[h][w] = acc[h][w] + OWIDTH'(1);
            end
          end
        end
      end
    end
    // Presented row is taken from next-state accumulators so the final COMP edge is included
    ofm_nxt = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      if (state_nxt == DRAIN && RW'(h) == row_nxt) begin
        for (int w = 0; w < WIDTH; w++) ofm_nxt[w*OWIDTH +: OWIDTH] = acc_nxt[h][w];
      end
    end
  end

  // State, outputs, operand latches and systolic bit/sign pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc       <= '0;
      row       <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      ofm_valid <= 1'b0;
      ofm_row   <= '0;
      ofm       <= '0;
      for (int w = 0; w < WIDTH; w++) begin
        wmag_q[w] <= '0;
        wsgn_q[w] <= 1'b0;
      end
      for (int h = 0; h < HEIGHT; h++) begin
        imag_q[h] <= '0;
        for (int w = 0; w < WIDTH; w++) begin
          bit_q[h][w] <= 1'b0;
          sgn_q[h][w] <= 1'b0;
          cnt[h][w]   <= '0;
          acc[h][w]   <= '0;
        end
      end
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      row       <= row_nxt;
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      ofm_valid <= (state_nxt == DRAIN);
      ofm_row   <= row_nxt;
      ofm       <= ofm_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      if (accept) begin
        last_q <= last;
        for (int w = 0; w < WIDTH; w++) begin
          wmag_q[w] <= wght[w*IWIDTH +: M];
          wsgn_q[w] <= wght[w*IWIDTH + M];
        end
      end
      for (int h = 0; h < HEIGHT; h++) begin
        if (accept) begin
          imag_q[h]   <= ifm[h*IWIDTH +: M];
          bit_q[h][0] <= (ifm[h*IWIDTH +: M] != M'(0));
          sgn_q[h][0] <= ifm[h*IWIDTH + M];
          for (int w = 1; w < WIDTH; w++) begin
            bit_q[h][w] <= 1'b0;
            sgn_q[h][w] <= 1'b0;
          end
        end else if (state == COMP) begin
          bit_q[h][0] <= col0_bit[h];
          for (int w = 1; w < WIDTH; w++) begin
            bit_q[h][w] <= bit_q[h][w-1];
            sgn_q[h][w] <= sgn_q[h][w-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_array_urate_os.sv
// Directed bench: two 2x2 arrays (16-bit and 8-bit accumulators) on shared stimulus.
module tb_array_urate_os;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, acc_clr, last, ofm_ready;
  logic [15:0] ifm, wght;
  logic        in_ready, busy, ofm_valid, ofm_row;
  logic [31:0] ofm;
  logic        in_ready8, busy8, ofm_valid8, ofm_row8;
  logic [15:0] ofm8;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  array_urate_os #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc_clr(acc_clr), .last(last), .ifm(ifm), .wght(wght), .busy(busy),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_row(ofm_row), .ofm(ofm));

  array_urate_os #(.HEIGHT(2), .WIDTH(2), .IWIDTH(8), .OWIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .acc_clr(acc_clr), .last(last), .ifm(ifm), .wght(wght), .busy(busy8),
    .ofm_valid(ofm_valid8), .ofm_ready(ofm_ready), .ofm_row(ofm_row8), .ofm(ofm8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one step when the array is ready; inputs change 1 time unit after edges
  task automatic do_step(input logic [15:0] i, input logic [15:0] w, input logic clr, input logic lst);
    int n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("step_ready", 64'(in_ready), 64'd1);
    ifm = i; wght = w; acc_clr = clr; last = lst; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0; last = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  // Count edges until COMP ends
  task automatic wait_comp(input int exp_n);
    int n = 0;
    while (!in_ready && !ofm_valid && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("comp_len", 64'(n), 64'(exp_n));
  endtask

  task automatic drain(input logic [1:0][31:0] e16, input logic [1:0][15:0] e8);
    for (int r = 0; r < 2; r++) begin
      chk("drain_valid", 64'(ofm_valid), 64'd1);
      chk("drain_row", 64'(ofm_row), 64'(r));
      chk("drain_ofm16", 64'(ofm), 64'(e16[r]));
      chk("drain_ofm8", 64'(ofm8), 64'(e8[r]));
      chk("drain_in_ready", 64'(in_ready), 64'd0);
      ofm_ready = 1'b1;
      @(posedge clk); #1;
      ofm_ready = 1'b0;
    end
    chk("post_drain_valid", 64'(ofm_valid), 64'd0);
    chk("post_drain_row", 64'(ofm_row), 64'd0);
    chk("post_drain_ready", 64'(in_ready), 64'd1);
    chk("post_drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; last = 1'b0; ofm_ready = 1'b0;
    ifm = '0; wght = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ofm_valid", 64'(ofm_valid), 64'd0);
    chk("rst_ofm_row", 64'(ofm_row), 64'd0);
    chk("rst_ofm", 64'(ofm), 64'd0);
    chk("rst_ofm8", 64'(ofm8), 64'd0);

    // 100 x 64 -> 50, 100 x 0 -> 0; backpressure and ignored in_valid during drain
    do_step({8'd100, 8'd100}, {8'd0, 8'd64}, 1'b1, 1'b1);
    wait_comp(129);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; acc_clr = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 64'(ofm_valid), 64'd1);
      chk("bp_row", 64'(ofm_row), 64'd0);
      chk("bp_ofm", 64'(ofm), 64'h0000_0032);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; acc_clr = 1'b0;
    drain({32'h0000_0032, 32'h0000_0032}, {16'h0032, 16'h0032});

    // Sign: -100 x 64 -> -50; negative zero x 64 -> 0
    do_step({8'h80, 8'hE4}, {8'd0, 8'd64}, 1'b1, 1'b1);
    wait_comp(129);
    drain({32'h0000_0000, 32'h0000_FFCE}, {16'h0000, 16'h00CE});

    // Three accumulating steps of 127 x 127 -> 381; 8-bit saturates at 127
    do_step({8'h7F, 8'h7F}, {8'h7F, 8'h7F}, 1'b1, 1'b0);
    wait_comp(129);
    do_step({8'h7F, 8'h7F}, {8'h7F, 8'h7F}, 1'b0, 1'b0);
    wait_comp(129);
    do_step({8'h7F, 8'h7F}, {8'h7F, 8'h7F}, 1'b0, 1'b1);
    wait_comp(129);
    drain({32'h017D_017D, 32'h017D_017D}, {16'h7F7F, 16'h7F7F});

    // Mixed signs, two steps -> +/-254; 8-bit clamps at 127 / -128
    do_step({8'h7F, 8'hFF}, {8'hFF, 8'h7F}, 1'b1, 1'b0);
    wait_comp(129);
    do_step({8'h7F, 8'hFF}, {8'hFF, 8'h7F}, 1'b0, 1'b1);
    wait_comp(129);
    drain({32'hFF02_00FE, 32'h00FE_FF02}, {16'h807F, 16'h7F80});

    // Reset mid-COMP wipes residue; next step without clear yields clean 50
    do_step({8'd100, 8'd100}, {8'd0, 8'd64}, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ofm_valid", 64'(ofm_valid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_step({8'd100, 8'd100}, {8'd0, 8'd64}, 1'b0, 1'b1);
    wait_comp(129);
    drain({32'h0000_0032, 32'h0000_0032}, {16'h0032, 16'h0032});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
